// File: rtl/laser_link_pkg.sv
// laser_link_pkg: shared mode/state types and small helpers for the laser link controller.
package laser_link_pkg;
    typedef enum logic [1:0] {MODE_ECHO, MODE_LINK, MODE_LOOPBACK, MODE_BEACON} mode_t;
    typedef enum logic [1:0] {IDLE, FETCH, DISPATCH} state_t;
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
endpackage

// File: rtl/laser_link_ctrl_rx_skid_fifo.sv
// rx_skid_fifo: first-word-fall-through register FIFO holding laser RX bytes until the host queue accepts them.
module rx_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0] cnt_q;
    logic wr_en;
    logic rd_en;
    assign full_o = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign rd_en = pop_i && !empty_o;
    // a pop in the same cycle frees the slot a full FIFO needs for the push
    assign wr_en = push_i && (!full_o || rd_en);
    assign data_o = mem_q[rd_q];
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_q + AW'(wr_en);
            rd_q <= rd_q + AW'(rd_en);
            cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    always_ff @(posedge clock_i) begin
        if (wr_en) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/laser_link_ctrl.sv
// laser_link_ctrl: mode-selectable byte router between host FTDI queues, NUM_LANES laser TX lanes and one laser RX.
module laser_link_ctrl
    import laser_link_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               NUM_LANES  = 2,
    parameter int               RX_DEPTH   = 4,
    parameter logic [WIDTH-1:0] BEACON     = 8'h0A,
    parameter int               TX_TIMEOUT = 4096
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic                 en_i,
    input  logic [1:0]           mode_i,
    input  logic                 rdq_empty_i,
    input  logic [WIDTH-1:0]     rdq_data_i,
    output logic                 rdq_rdreq_o,
    input  logic                 wrq_full_i,
    output logic                 wrq_wrreq_o,
    output logic [WIDTH-1:0]     wrq_data_o,
    output logic [NUM_LANES-1:0] tx_start_o,
    output logic [WIDTH-1:0]     tx_data_o,
    input  logic [NUM_LANES-1:0] tx_done_i,
    input  logic                 rx_valid_i,
    input  logic [WIDTH-1:0]     rx_data_i,
    output logic [NUM_LANES-1:0] lane_busy_o,
    output logic [15:0]          rx_drop_count_o,
    output logic [15:0]          timeout_count_o
);
    localparam int LW = lane_w(NUM_LANES);
    localparam int TW = $clog2(TX_TIMEOUT + 1);
    state_t state_q, state_d;
    mode_t mode_q, am;
    logic run_q;
    logic [LW-1:0] rr_q, rr_d, pick, pick_nxt, idx;
    logic pick_ok;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [NUM_LANES-1:0] busy_q, tmo;
    logic [TW-1:0] timer_q [NUM_LANES];
    logic [3:0] tmo_n;
    logic [15:0] drop_q, to_q;
    logic go, pop, drop, skid_full, skid_empty;
    logic [WIDTH-1:0] skid_data;
    assign am = (state_q == IDLE) ? mode_t'(mode_i) : mode_q;
    // run_q keeps launch strobes quiet until the first clock after reset release
    assign go = run_q && en_i;
    assign drop = rx_valid_i && skid_full && !pop;
    assign lane_busy_o = busy_q;
    assign rx_drop_count_o = drop_q;
    assign timeout_count_o = to_q;
    rx_skid_fifo #(.WIDTH(WIDTH), .DEPTH(RX_DEPTH)) u_skid (
        .clock_i(clock_i),
        .reset_n_i(reset_n_i),
        .push_i(rx_valid_i),
        .pop_i(pop),
        .data_i(rx_data_i),
        .data_o(skid_data),
        .full_o(skid_full),
        .empty_o(skid_empty)
    );
    always_comb begin
        pick = '0;
        pick_ok = 1'b0;
        idx = '0;
        tmo = '0;
        tmo_n = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = LW'((int'(rr_q) + k) % NUM_LANES);
            if (!pick_ok && !busy_q[idx]) begin
                pick = idx;
                pick_ok = 1'b1;
            end
            tmo[k] = busy_q[k] && !tx_done_i[k] && timer_q[k] == TW'(TX_TIMEOUT - 1);
            tmo_n = tmo_n + 4'(tmo[k]);
        end
        pick_nxt = (int'(pick) == NUM_LANES - 1) ? '0 : pick + LW'(1);
    end
    always_comb begin
        state_d = state_q;
        hold_d = hold_q;
        rr_d = rr_q;
        pop = 1'b0;
        rdq_rdreq_o = 1'b0;
        wrq_wrreq_o = 1'b0;
        wrq_data_o = '0;
        tx_start_o = '0;
        tx_data_o = '0;
        case (state_q)
            IDLE: begin
                if (go && am == MODE_ECHO && !rdq_empty_i && !wrq_full_i) begin
                    rdq_rdreq_o = 1'b1;
                    state_d = FETCH;
                end else if (go && am == MODE_LINK && !rdq_empty_i && pick_ok) begin
                    rdq_rdreq_o = 1'b1;
                    state_d = FETCH;
                end else if (go && am == MODE_LOOPBACK && !skid_empty && pick_ok) begin
                    pop = 1'b1;
                    tx_start_o = NUM_LANES'(1) << pick;
                    tx_data_o = skid_data;
                    rr_d = pick_nxt;
                end else if (go && am == MODE_BEACON && pick_ok) begin
                    tx_start_o = ~busy_q;
                    tx_data_o = BEACON;
                end
            end
            FETCH: begin
                // an echo byte meeting a full host queue is parked in DISPATCH instead of lost
                if (mode_q != MODE_ECHO || wrq_full_i) begin
                    hold_d = rdq_data_i;
                    state_d = DISPATCH;
                end else begin
                    wrq_wrreq_o = 1'b1;
                    wrq_data_o = rdq_data_i;
                    if (go && !rdq_empty_i) rdq_rdreq_o = 1'b1;
                    else state_d = IDLE;
                end
            end
            DISPATCH: begin
                if (mode_q == MODE_ECHO) begin
                    if (!wrq_full_i) begin
                        wrq_wrreq_o = 1'b1;
                        wrq_data_o = hold_q;
                        state_d = IDLE;
                    end
                end else if (pick_ok) begin
                    tx_start_o = NUM_LANES'(1) << pick;
                    tx_data_o = hold_q;
                    rr_d = pick_nxt;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (run_q && am != MODE_LOOPBACK && !wrq_wrreq_o && !wrq_full_i && !skid_empty) begin
            pop = 1'b1;
            wrq_wrreq_o = 1'b1;
            wrq_data_o = skid_data;
        end
    end
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            mode_q <= MODE_ECHO;
            run_q <= 1'b0;
            rr_q <= '0;
            hold_q <= '0;
            busy_q <= '0;
            drop_q <= '0;
            to_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) timer_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mode_q <= am;
            run_q <= 1'b1;
            rr_q <= rr_d;
            hold_q <= hold_d;
            drop_q <= sat_add(drop_q, {3'd0, drop});
            to_q <= sat_add(to_q, tmo_n);
            for (int i = 0; i < NUM_LANES; i++) begin
                if (tx_start_o[i]) begin
                    busy_q[i] <= 1'b1;
                    timer_q[i] <= '0;
                end else if (tmo[i] || (busy_q[i] && tx_done_i[i])) begin
                    busy_q[i] <= 1'b0;
                end else if (busy_q[i]) begin
                    timer_q[i] <= timer_q[i] + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_laser_link_ctrl.sv
// tb_laser_link_ctrl: directed vector table plus hand-written multi-cycle sequences for laser_link_ctrl.
module tb_laser_link_ctrl;
    logic clk = 1'b0;
    logic reset_n, en, rdq_empty, rdq_rdreq, wrq_full, wrq_wrreq, rx_valid;
    logic [1:0] mode, tx_start, tx_done, lane_busy;
    logic [7:0] rdq_data, wrq_data, tx_data, rx_data;
    logic [15:0] rx_drop_count, timeout_count;
    typedef struct {
        logic en; logic [1:0] mode; logic emp; logic [7:0] rdat; logic full;
        logic [1:0] done; logic rxv; logic [7:0] rxd;
        logic rdreq; logic wrreq; logic [7:0] wdat; logic [1:0] start; logic [7:0] tdat; logic [1:0] busy;
    } vec_t;
    vec_t tbl [22];
    int n_cmp = 0;
    int n_bad = 0;
    laser_link_ctrl #(.WIDTH(8), .NUM_LANES(2), .RX_DEPTH(4), .BEACON(8'h0A), .TX_TIMEOUT(16)) dut (
        .clock_i(clk), .reset_n_i(reset_n), .en_i(en), .mode_i(mode),
        .rdq_empty_i(rdq_empty), .rdq_data_i(rdq_data), .rdq_rdreq_o(rdq_rdreq),
        .wrq_full_i(wrq_full), .wrq_wrreq_o(wrq_wrreq), .wrq_data_o(wrq_data),
        .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_done_i(tx_done),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .lane_busy_o(lane_busy),
        .rx_drop_count_o(rx_drop_count), .timeout_count_o(timeout_count)
    );
    initial forever #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] outs();
        return {10'd0, rdq_rdreq, wrq_wrreq, wrq_data, tx_start, tx_data, lane_busy};
    endfunction
    initial begin
        int n;
        // en mode emp rdat full done rxv rxd | rdreq wrreq wdat start tdat busy
        tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0};
        tbl[1]  = '{1, 0, 0, 8'h11, 0, 0, 0, 8'h00, 1, 1, 8'h11, 0, 8'h00, 0};
        tbl[2]  = '{1, 0, 0, 8'h22, 0, 0, 0, 8'h00, 1, 1, 8'h22, 0, 8'h00, 0};
        tbl[3]  = '{1, 0, 1, 8'h33, 0, 0, 0, 8'h00, 0, 1, 8'h33, 0, 8'h00, 0};
        tbl[4]  = '{1, 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0};
        tbl[5]  = '{1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0};
        tbl[6]  = '{1, 1, 0, 8'hA1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0};
        tbl[7]  = '{1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA1, 0};
        tbl[8]  = '{1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1};
        tbl[9]  = '{1, 1, 0, 8'hA2, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1};
        tbl[10] = '{1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2, 8'hA2, 1};
        tbl[11] = '{1, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 3};
        tbl[12] = '{1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 2};
        tbl[13] = '{1, 1, 1, 8'hA3, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 2};
        tbl[14] = '{1, 1, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA3, 2};
        tbl[15] = '{1, 1, 1, 8'h00, 0, 3, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 3};
        tbl[16] = '{1, 2, 1, 8'h00, 0, 0, 1, 8'h5C, 0, 0, 8'h00, 0, 8'h00, 0};
        tbl[17] = '{1, 2, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2, 8'h5C, 0};
        tbl[18] = '{1, 2, 1, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 2};
        tbl[19] = '{1, 2, 1, 8'h00, 0, 2, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 2};
        tbl[20] = '{0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0};
        tbl[21] = '{1, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0};
        reset_n = 1'b0; en = 1'b1; mode = 2'd0; rdq_empty = 1'b0; rdq_data = 8'h00;
        wrq_full = 1'b0; tx_done = 2'b00; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", outs(), 32'd0);
        check("reset_counts", {rx_drop_count, timeout_count}, 32'd0);
        reset_n = 1'b1;
        rdq_empty = 1'b1;
        nxt();
        for (int i = 0; i < 22; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; rdq_empty = tbl[i].emp; rdq_data = tbl[i].rdat;
            wrq_full = tbl[i].full; tx_done = tbl[i].done; rx_valid = tbl[i].rxv; rx_data = tbl[i].rxd;
            #4;
            check($sformatf("vec%0d", i), outs(),
                  {10'd0, tbl[i].rdreq, tbl[i].wrreq, tbl[i].wdat, tbl[i].start, tbl[i].tdat, tbl[i].busy});
            nxt();
        end
        wrq_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_data = 8'h01 + 8'(i);
            nxt();
        end
        rx_valid = 1'b0;
        wrq_full = 1'b0;
        check("drop_count", {16'd0, rx_drop_count}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            #4;
            check($sformatf("drain%0d", i), {wrq_wrreq, wrq_data}, {1'b1, 8'h01 + 8'(i)});
            nxt();
        end
        #4;
        check("drain_done", wrq_wrreq, 0);
        nxt();
        rx_valid = 1'b1; rx_data = 8'h77; rdq_empty = 1'b0;
        #4;
        check("prio_rd", {rdq_rdreq, wrq_wrreq}, 2'b10);
        nxt();
        rx_valid = 1'b0; rdq_data = 8'hE1; rdq_empty = 1'b1;
        #4;
        check("prio_echo", {wrq_wrreq, wrq_data}, {1'b1, 8'hE1});
        nxt();
        #4;
        check("prio_skid", {wrq_wrreq, wrq_data}, {1'b1, 8'h77});
        nxt();
        #4;
        check("prio_idle", wrq_wrreq, 0);
        nxt();
        mode = 2'd3;
        #4;
        check("beacon_launch", {tx_start, tx_data}, {2'b11, 8'h0A});
        check("timeout_pre", {16'd0, timeout_count}, 32'd0);
        nxt();
        n = 0;
        while (lane_busy == 2'b11 && n < 40) begin
            n++;
            nxt();
        end
        check("busy_cycles", n, 16);
        #4;
        check("beacon_relaunch", {tx_start, tx_data, lane_busy}, {2'b11, 8'h0A, 2'b00});
        check("timeout_count", {16'd0, timeout_count}, 32'd2);
        nxt();
        en = 1'b0; mode = 2'd1; tx_done = 2'b11;
        nxt();
        tx_done = 2'b00; en = 1'b1; rdq_empty = 1'b0;
        #4;
        check("link_fetch", rdq_rdreq, 1);
        nxt();
        rdq_data = 8'hB7; rdq_empty = 1'b1;
        nxt();
        #1;
        check("dispatch_pre", {tx_start, tx_data}, {2'b01, 8'hB7});
        reset_n = 1'b0;
        #1;
        check("reset_outs_mid", outs(), 32'd0);
        check("reset_counts_mid", {rx_drop_count, timeout_count}, 32'd0);
        nxt();
        reset_n = 1'b1;
        nxt();
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
